// File: rtl/rope_object.sv
// rope_object -- per-rope pixel generator feeding the rope priority mux.
//
// Draws one vertical rope of ROPE_WIDTH columns starting at (TOP_X, TOP_Y)
// whose length animates once per frame through
// RETRACTED -> EXTENDING -> EXTENDED -> RETRACTING -> RETRACTED.
//
// Ports:
//   clk           system pixel clock
//   reset         asynchronous, active-high reset
//   pixelX/Y      current VGA column / row (11 bits)
//   startOfFrame  one-cycle pulse per frame; animation steps on it
//   enable        1 = animation runs, 0 = animation frozen
//   drawRequest   current pixel lies on the rope (registered, 1 clk latency)
//   RGBout        RGB332 rope colour on a hit, 8'h00 otherwise (registered)
//   ropeBottomY   TOP_Y+len-1 (registered)
//   ropeState     0 RETRACTED, 1 EXTENDING, 2 EXTENDED, 3 RETRACTING
//
// Optional build macro: ROPE_STRIPES_EN -- hit pixels whose row offset from
// TOP_Y has bit 3 set are drawn in STRIPE_COLOR (8-row bands).

module rope_object #(
   parameter int unsigned      TOP_X        = 160,
   parameter int unsigned      TOP_Y        = 32,
   parameter int unsigned      ROPE_WIDTH   = 4,
   parameter int unsigned      MIN_LEN      = 64,
   parameter int unsigned      MAX_LEN      = 320,
   parameter int unsigned      STEP         = 2,
   parameter int unsigned      HOLD_FRAMES  = 60,
   parameter logic [7:0]       ROPE_COLOR   = 8'hB4,
   parameter logic [7:0]       STRIPE_COLOR = 8'h6C
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        startOfFrame,
   input  logic        enable,
   output logic        drawRequest,
   output logic [7:0]  RGBout,
   output logic [10:0] ropeBottomY,
   output logic [1:0]  ropeState
);

   typedef enum logic [1:0] {
      RETRACTED  = 2'd0,
      EXTENDING  = 2'd1,
      EXTENDED   = 2'd2,
      RETRACTING = 2'd3
   } state_t;

   localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_FRAMES - 1);
   localparam logic [11:0]        MIN_L     = 12'(MIN_LEN);
   localparam logic [11:0]        MAX_L     = 12'(MAX_LEN);
   localparam logic [11:0]        STEP_L    = 12'(STEP);
   localparam logic signed [12:0] MIN_S     = 13'(MIN_LEN);
   localparam logic signed [12:0] STEP_S    = 13'(STEP);
   localparam logic [11:0]        X_LO      = 12'(TOP_X);
   localparam logic [11:0]        X_HI      = 12'(TOP_X + ROPE_WIDTH);
   localparam logic [11:0]        Y_LO      = 12'(TOP_Y);
   localparam logic [10:0]        BOTTOM_RST = 11'(TOP_Y + MIN_LEN - 1);

   state_t         state;
   logic [10:0]    len;
   logic [HW-1:0]  hold_cnt;

   logic [11:0]        len_up;
   logic [11:0]        len_up_sat;
   logic signed [12:0] len_dn;
   logic [11:0]        len_dn_sat;
   logic               hit;
   logic               stripe;
   logic [7:0]         colour;

   // Next-length candidates: 12-bit add cannot wrap, signed subtract cannot
   // underflow, so saturation compares are exact.
   always_comb begin
      len_up     = {1'b0, len} + STEP_L;
      len_up_sat = (len_up >= MAX_L) ? MAX_L : len_up;
      len_dn     = $signed({2'b00, len}) - STEP_S;
      len_dn_sat = (len_dn <= MIN_S) ? MIN_L : len_dn[11:0];
   end

   // Hit test uses the current (pre-update) len, so a frame pulse on a hit
   // pixel still sees the old length.
   always_comb begin
      hit = ({1'b0, pixelX} >= X_LO) && ({1'b0, pixelX} < X_HI) &&
            ({1'b0, pixelY} >= Y_LO) && ({1'b0, pixelY} < (Y_LO + {1'b0, len}));
   end

`ifdef ROPE_STRIPES_EN
   logic [10:0] row_off;
   always_comb begin
      row_off = pixelY - 11'(TOP_Y);
      stripe  = row_off[3];
   end
`else
   always_comb stripe = 1'b0;
`endif

   always_comb colour = stripe ? STRIPE_COLOR : ROPE_COLOR;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RETRACTED;
         len         <= 11'(MIN_LEN);
         hold_cnt    <= '0;
         drawRequest <= 1'b0;
         RGBout      <= '0;
         ropeBottomY <= BOTTOM_RST;
         ropeState   <= RETRACTED;
      end else begin
         drawRequest <= hit;
         RGBout      <= hit ? colour : '0;
         ropeBottomY <= 11'(Y_LO + {1'b0, len} - 12'd1);
         ropeState   <= state;

         if (startOfFrame && enable) begin
            case (state)
               RETRACTED: begin
                  if (hold_cnt == HOLD_LAST) begin
                     hold_cnt <= '0;
                     state    <= EXTENDING;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               EXTENDING: begin
                  len <= len_up_sat[10:0];
                  if (len_up_sat == MAX_L) state <= EXTENDED;
               end
               EXTENDED: begin
                  if (hold_cnt == HOLD_LAST) begin
                     hold_cnt <= '0;
                     state    <= RETRACTING;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               RETRACTING: begin
                  len <= len_dn_sat[10:0];
                  if (len_dn_sat == MIN_L) state <= RETRACTED;
               end
               default: state <= RETRACTED;
            endcase
         end
      end
   end

endmodule
